mem_access: RTL and testbench
=============================

# mem_access

Memory-access stage of the five-stage MIPS core, directly downstream of the execute stage. It takes the execute result (an ALU value or a load/store effective address) plus the rt store data and runs one data-bus transaction per load/store. Transactions use a request/acknowledge handshake with byte-lane strobes. Loads are aligned and sign/zero-extended, and the stage presents a registered writeback bundle. The stage stalls the front of the pipeline while a bus access is outstanding and flags misaligned accesses.

## Interface
Parameters:
- ADDR_W, 32, data-bus address width.

Ports:
- sys_clk  in  1  single clock, all state on rising edge.
- rst  in  1  reset; synchronous, active-high.
- ex_valid  in  1  execute bundle valid this cycle.
- ex_result  in  32  ALU result / effective address.
- ex_store_data  in  32  rt value for stores.
- ex_opcode  in  6  instruction opcode.
- ex_is_load_store  in  1  instruction is lb/lh/lw/lbu/lhu/sb/sh/sw.
- ex_wb_en  in  1  instruction writes a register.
- ex_wb_reg  in  5  destination register index.
- stall  out  1  hold execute and earlier stages.
- dbus_req  out  1  bus request.
- dbus_we  out  1  1 = write.
- dbus_addr  out  ADDR_W  word-aligned address, bits [1:0] = 0.
- dbus_wstrb  out  4  write byte-lane enables, lane 0 = bits [7:0].
- dbus_wdata  out  32  write data, lane-replicated.
- dbus_ack  in  1  transaction complete.
- dbus_rdata  in  32  read word, valid with dbus_ack.
- wb_valid  out  1  writeback bundle valid.
- wb_en  out  1  register write enable.
- wb_reg  out  5  destination index.
- wb_data  out  32  writeback value.
- addr_err  out  1  misaligned access, one-cycle pulse with wb_valid.

## Operation
- Opcodes: lb 100000, lh 100001, lw 100011, lbu 100100, lhu 100101, sb 101000, sh 101001, sw 101011. Any other opcode with ex_is_load_store = 1 is treated as lw.
- Misalignment:
  - Halfword accesses (lh/lhu/sh) are misaligned when ex_result[0] = 1.
  - Word accesses (lw/sw) are misaligned when ex_result[1:0] ≠ 0.
  - A misaligned access issues no bus request. It produces wb_valid = 1, wb_en = 0, addr_err = 1.
- FSM has two states: IDLE and BUSY.
  - In IDLE, an accepted aligned load/store latches address, strobes, write data, opcode, byte offset and destination, then enters BUSY.
  - In BUSY, dbus_req = 1 and all bus outputs are held stable until dbus_ack. On the ack edge the FSM returns to IDLE.
- Non-memory instructions: the pass-through register captures ex_result/ex_wb_en/ex_wb_reg, and wb_valid is asserted the next cycle.
- Store lanes:
  - sb: wstrb = 1 << off, wdata = {4{byte}}.
  - sh: wstrb = 0011 or 1100, wdata = {2{half}}.
  - sw: wstrb = 1111.
  - off = ex_result[1:0].
- Loads:
  - The byte or half at off is selected from dbus_rdata.
  - lb/lh sign-extend; lbu/lhu zero-extend.
  - lw passes the word through.
  - wb_en is forced to 1 for loads and to 0 for stores.
- stall = (state == BUSY), combinational. While stall = 1, ex_valid is ignored and the upstream stages must hold their bundle.
- dbus_ack outside BUSY is ignored.

## Timing
- Reset: state = IDLE; dbus_req, dbus_we, dbus_wstrb, dbus_addr, dbus_wdata, wb_valid, wb_en, wb_reg, wb_data and addr_err all = 0.
- Reset during BUSY drops dbus_req on the next cycle. A late ack is ignored, and no wb_valid is produced for the aborted access.
- Pass-through instructions and misaligned accesses have 1-cycle latency: accepted in cycle T, wb_valid in T+1.
- Loads and stores accepted in cycle T:
  - dbus_req = 1 from T+1.
  - An ack in cycle T+k (k ≥ 1) gives wb_valid in T+k+1, and stall falls in T+k+1.
  - Minimum latency is 2 cycles.
- A new instruction is accepted in the same cycle stall falls. Back-to-back loads therefore give requests in T+1 and T+3 at zero wait states.
- wb_valid and addr_err are single-cycle pulses per instruction. wb_valid is 0 in every cycle with no completion.

## Structure
- Package mem_pkg holds:
  - Opcode localparams (OP_LB … OP_SW).
  - The state enum (S_IDLE, S_BUSY).
  - The access-size encoding (SZ_BYTE, SZ_HALF, SZ_WORD).
- Sub-module load_align is combinational. Inputs: rdata[31:0], off[1:0], size, unsigned. Output: data[31:0]. It is reused for the instruction-fetch path.

## Test plan
- lw at 0x100, rdata = 0xDEADBEEF, ack one cycle after req → dbus_addr = 0x100, wb_data = 0xDEADBEEF, wb_en = 1, wb_valid 2 cycles after accept.
- lb at 0x103 with rdata = 0x80000000 gives wb_data = 0xFFFFFF80; lbu at the same address gives 0x00000080.
- sh at 0x202, data 0x1234ABCD → wstrb = 1100, wdata = 0xABCDABCD, dbus_addr = 0x200, wb_en = 0.
- lw at 0x101 → no dbus_req; wb_valid = 1, addr_err = 1, wb_en = 0 in the next cycle.
- Load with ack delayed 5 cycles → stall high for 5 cycles; address and strobes stable; the upstream bundle presented during stall is not captured until stall falls.
- rst asserted in the second BUSY cycle, followed by a late ack → dbus_req = 0 after reset and no wb_valid.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: opcodes, FSM states and access-size encoding shared by the memory-access stage
package mem_pkg;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;
  typedef enum logic {S_IDLE, S_BUSY} state_t;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;
  function automatic size_t op_size(input logic [5:0] op);
    return (op == OP_LB || op == OP_LBU || op == OP_SB) ? SZ_BYTE :
           (op == OP_LH || op == OP_LHU || op == OP_SH) ? SZ_HALF : SZ_WORD;
  endfunction
endpackage

// File: rtl/mem_access_if.sv
// mem_access_if: request/acknowledge data bus with byte-lane strobes
interface mem_access_if #(parameter int ADDR_W = 32);
  logic req;
  logic we;
  logic [ADDR_W-1:0] addr;
  logic [3:0] wstrb;
  logic [31:0] wdata;
  logic ack;
  logic [31:0] rdata;
  modport master(output req, we, addr, wstrb, wdata, input ack, rdata);
  modport slave(input req, we, addr, wstrb, wdata, output ack, rdata);
endinterface

// File: rtl/load_align.sv
// load_align: selects the addressed byte/half of a read word and sign/zero-extends it
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  size_t       size,
  input  logic        is_unsigned,
  output logic [31:0] data
);
  logic [7:0] b;
  logic [15:0] h;
  assign b = rdata[8*off +: 8];
  assign h = off[1] ? rdata[31:16] : rdata[15:0];
  assign data = size == SZ_BYTE ? {{24{b[7] & ~is_unsigned}}, b} :
                size == SZ_HALF ? {{16{h[15] & ~is_unsigned}}, h} : rdata;
endmodule

// File: rtl/mem_access.sv
// mem_access: MIPS memory stage; one bus transaction per load/store, registered writeback bundle
module mem_access
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [31:0] ex_result,
  input  logic [31:0] ex_store_data,
  input  logic [5:0]  ex_opcode,
  input  logic        ex_is_load_store,
  input  logic        ex_wb_en,
  input  logic [4:0]  ex_wb_reg,
  output logic        stall,
  mem_access_if.master dbus,
  output logic        wb_valid,
  output logic        wb_en,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data,
  output logic        addr_err
);
  state_t state, state_nx;
  size_t size, size_q;
  logic is_store, mis, go, uns_q;
  logic [1:0] off, off_q;
  logic [4:0] dest_q;
  logic [31:0] ld_data;
  assign off = ex_result[1:0];
  assign size = op_size(ex_opcode);
  assign is_store = ex_opcode inside {OP_SB, OP_SH, OP_SW};
  assign mis = size == SZ_HALF ? off[0] : (size == SZ_WORD && off != 2'b00);
  assign go = ex_valid && ex_is_load_store && !mis;
  assign stall = state == S_BUSY;
  assign dbus.req = stall;
  always_ff @(posedge sys_clk) begin
    if (rst) state <= S_IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state == S_IDLE ? (go ? S_BUSY : S_IDLE) : (dbus.ack ? S_IDLE : S_BUSY);
  end
  load_align u_align (
    .rdata(dbus.rdata),
    .off(off_q),
    .size(size_q),
    .is_unsigned(uns_q),
    .data(ld_data)
  );
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      dbus.we <= 1'b0;
      dbus.addr <= '0;
      dbus.wstrb <= 4'b0000;
      dbus.wdata <= 32'd0;
      size_q <= SZ_WORD;
      off_q <= 2'b00;
      uns_q <= 1'b0;
      dest_q <= 5'd0;
      wb_valid <= 1'b0;
      wb_en <= 1'b0;
      wb_reg <= 5'd0;
      wb_data <= 32'd0;
      addr_err <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      addr_err <= 1'b0;
      if (state == S_IDLE && ex_valid) begin
        if (go) begin
          dbus.we <= is_store;
          dbus.addr <= {ex_result[ADDR_W-1:2], 2'b00};
          dbus.wstrb <= !is_store ? 4'b0000 : size == SZ_BYTE ? 4'b0001 << off :
                        size == SZ_HALF ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
          dbus.wdata <= size == SZ_BYTE ? {4{ex_store_data[7:0]}} :
                        size == SZ_HALF ? {2{ex_store_data[15:0]}} : ex_store_data;
          size_q <= size;
          off_q <= off;
          uns_q <= ex_opcode == OP_LBU || ex_opcode == OP_LHU;
          dest_q <= ex_wb_reg;
        end else begin
          // pass-through ALU result, or a misaligned access reported without a bus cycle
          wb_valid <= 1'b1;
          wb_en <= ex_wb_en && !ex_is_load_store;
          wb_reg <= ex_wb_reg;
          wb_data <= ex_result;
          addr_err <= ex_is_load_store;
        end
      end else if (state == S_BUSY && dbus.ack) begin
        wb_valid <= 1'b1;
        wb_en <= !dbus.we;
        wb_reg <= dest_q;
        wb_data <= dbus.we ? 32'd0 : ld_data;
      end
    end
  end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed vectors with a writeback scoreboard checked by an independent monitor
module tb_mem_access;
  import mem_pkg::*;
  logic sys_clk = 1'b0;
  logic rst = 1'b1;
  logic ex_valid = 1'b0;
  logic [31:0] ex_result = 32'd0;
  logic [31:0] ex_store_data = 32'd0;
  logic [5:0] ex_opcode = 6'd0;
  logic ex_is_load_store = 1'b0;
  logic ex_wb_en = 1'b0;
  logic [4:0] ex_wb_reg = 5'd0;
  logic stall, wb_valid, wb_en, addr_err;
  logic [4:0] wb_reg;
  logic [31:0] wb_data;
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  typedef struct {
    logic en;
    logic [4:0] rg;
    logic [31:0] data;
    logic chk_data;
    logic err;
    int cyc;
  } exp_t;
  exp_t sb_q[$];

  mem_access_if #(.ADDR_W(32)) dbus ();

  mem_access #(.ADDR_W(32)) dut (
    .sys_clk(sys_clk),
    .rst(rst),
    .ex_valid(ex_valid),
    .ex_result(ex_result),
    .ex_store_data(ex_store_data),
    .ex_opcode(ex_opcode),
    .ex_is_load_store(ex_is_load_store),
    .ex_wb_en(ex_wb_en),
    .ex_wb_reg(ex_wb_reg),
    .stall(stall),
    .dbus(dbus),
    .wb_valid(wb_valid),
    .wb_en(wb_en),
    .wb_reg(wb_reg),
    .wb_data(wb_data),
    .addr_err(addr_err)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic en, input logic [4:0] rg, input logic [31:0] data,
                      input logic cd, input logic err, input int lat);
    exp_t e;
    e.en = en;
    e.rg = rg;
    e.data = data;
    e.chk_data = cd;
    e.err = err;
    e.cyc = lat > 0 ? cyc + lat : -1;
    sb_q.push_back(e);
  endtask

  task automatic issue(input logic [5:0] op, input logic [31:0] res, input logic [31:0] sd,
                       input logic ls, input logic wbe, input logic [4:0] rg);
    ex_opcode = op;
    ex_result = res;
    ex_store_data = sd;
    ex_is_load_store = ls;
    ex_wb_en = wbe;
    ex_wb_reg = rg;
    ex_valid = 1'b1;
    @(posedge sys_clk);
    #1;
    ex_valid = 1'b0;
  endtask

  // d wait cycles with the bus held, then one ack cycle
  task automatic serve(input logic [31:0] a, input logic [3:0] s, input logic [31:0] wd,
                       input logic we, input logic [31:0] rd, input int d);
    int w;
    w = 0;
    while (!dbus.req && w < 20) begin
      @(posedge sys_clk);
      #1;
      w++;
    end
    chk("req_latency", w, 0);
    for (int i = 0; i <= d; i++) begin
      chk("dbus_addr", dbus.addr, a);
      chk("dbus_wstrb", {28'd0, dbus.wstrb}, {28'd0, s});
      chk("dbus_wdata", dbus.wdata, wd);
      chk("dbus_we", {31'd0, dbus.we}, {31'd0, we});
      chk("stall_busy", {31'd0, stall}, 32'd1);
      if (i < d) begin
        @(posedge sys_clk);
        #1;
      end
    end
    dbus.ack = 1'b1;
    dbus.rdata = rd;
    @(posedge sys_clk);
    #1;
    dbus.ack = 1'b0;
    dbus.rdata = 32'd0;
  endtask

  always @(negedge sys_clk) begin
    exp_t e;
    if (addr_err) chk("err_with_valid", {31'd0, wb_valid}, 32'd1);
    if (wb_valid) begin
      if (sb_q.size() == 0) chk("unexpected_wb", {31'd0, wb_valid}, 32'd0);
      else begin
        e = sb_q.pop_front();
        chk("wb_en", {31'd0, wb_en}, {31'd0, e.en});
        chk("wb_reg", {27'd0, wb_reg}, {27'd0, e.rg});
        chk("addr_err", {31'd0, addr_err}, {31'd0, e.err});
        if (e.chk_data) chk("wb_data", wb_data, e.data);
        if (e.cyc >= 0) chk("wb_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    dbus.ack = 1'b0;
    dbus.rdata = 32'd0;
    repeat (2) @(posedge sys_clk);
    #1;
    chk("rst_req", {31'd0, dbus.req}, 32'd0);
    chk("rst_we", {31'd0, dbus.we}, 32'd0);
    chk("rst_wstrb", {28'd0, dbus.wstrb}, 32'd0);
    chk("rst_addr", dbus.addr, 32'd0);
    chk("rst_wdata", dbus.wdata, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_wb_en", {31'd0, wb_en}, 32'd0);
    chk("rst_wb_reg", {27'd0, wb_reg}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_addr_err", {31'd0, addr_err}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    rst = 1'b0;
    @(posedge sys_clk);
    #1;
    push(1'b1, 5'd3, 32'h12345678, 1'b1, 1'b0, 1);
    issue(6'b000000, 32'h12345678, 32'd0, 1'b0, 1'b1, 5'd3);
    push(1'b0, 5'd4, 32'h0000CAFE, 1'b1, 1'b0, 1);
    issue(6'b001000, 32'h0000CAFE, 32'd0, 1'b0, 1'b0, 5'd4);
    push(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 1'b0, 2);
    issue(OP_LW, 32'h100, 32'd0, 1'b1, 1'b1, 5'd5);
    serve(32'h100, 4'b0000, 32'd0, 1'b0, 32'hDEADBEEF, 0);
    push(1'b1, 5'd6, 32'hFFFFFF80, 1'b1, 1'b0, 2);
    issue(OP_LB, 32'h103, 32'd0, 1'b1, 1'b1, 5'd6);
    serve(32'h100, 4'b0000, 32'd0, 1'b0, 32'h80000000, 0);
    push(1'b1, 5'd7, 32'h00000080, 1'b1, 1'b0, 2);
    issue(OP_LBU, 32'h103, 32'd0, 1'b1, 1'b1, 5'd7);
    serve(32'h100, 4'b0000, 32'd0, 1'b0, 32'h80000000, 0);
    push(1'b1, 5'd14, 32'hFFFF8001, 1'b1, 1'b0, 2);
    issue(OP_LH, 32'h102, 32'd0, 1'b1, 1'b1, 5'd14);
    serve(32'h100, 4'b0000, 32'd0, 1'b0, 32'h80010000, 0);
    push(1'b1, 5'd15, 32'h00008001, 1'b1, 1'b0, 2);
    issue(OP_LHU, 32'h102, 32'd0, 1'b1, 1'b1, 5'd15);
    serve(32'h100, 4'b0000, 32'd0, 1'b0, 32'h80010000, 0);
    push(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 2);
    issue(OP_SH, 32'h202, 32'h1234ABCD, 1'b1, 1'b0, 5'd0);
    serve(32'h200, 4'b1100, 32'hABCDABCD, 1'b1, 32'd0, 0);
    push(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 2);
    issue(OP_SB, 32'h101, 32'h123456AB, 1'b1, 1'b0, 5'd0);
    serve(32'h100, 4'b0010, 32'hABABABAB, 1'b1, 32'd0, 0);
    push(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 2);
    issue(OP_SW, 32'h10, 32'h01020304, 1'b1, 1'b0, 5'd0);
    serve(32'h10, 4'b1111, 32'h01020304, 1'b1, 32'd0, 0);
    push(1'b1, 5'd8, 32'h89ABCDEF, 1'b1, 1'b0, 2);
    issue(6'b100010, 32'h20, 32'd0, 1'b1, 1'b1, 5'd8);
    serve(32'h20, 4'b0000, 32'd0, 1'b0, 32'h89ABCDEF, 0);
    push(1'b0, 5'd9, 32'd0, 1'b0, 1'b1, 1);
    issue(OP_LW, 32'h101, 32'd0, 1'b1, 1'b1, 5'd9);
    chk("mis_lw_no_req", {31'd0, dbus.req}, 32'd0);
    push(1'b0, 5'd10, 32'd0, 1'b0, 1'b1, 1);
    issue(OP_SH, 32'h203, 32'h5555, 1'b1, 1'b0, 5'd10);
    chk("mis_sh_no_req", {31'd0, dbus.req}, 32'd0);
    chk("mis_sh_stall", {31'd0, stall}, 32'd0);
    // slow ack while the next bundle waits upstream
    push(1'b1, 5'd11, 32'h0BADF00D, 1'b1, 1'b0, 6);
    issue(OP_LW, 32'h400, 32'd0, 1'b1, 1'b1, 5'd11);
    ex_opcode = 6'b000000;
    ex_result = 32'h77;
    ex_is_load_store = 1'b0;
    ex_wb_en = 1'b1;
    ex_wb_reg = 5'd12;
    ex_valid = 1'b1;
    serve(32'h400, 4'b0000, 32'd0, 1'b0, 32'h0BADF00D, 4);
    chk("stall_fall", {31'd0, stall}, 32'd0);
    push(1'b1, 5'd12, 32'h77, 1'b1, 1'b0, 1);
    @(posedge sys_clk);
    #1;
    ex_valid = 1'b0;
    // reset in the second busy cycle, then a stray ack
    issue(OP_LW, 32'h300, 32'd0, 1'b1, 1'b1, 5'd13);
    @(posedge sys_clk);
    #1;
    chk("busy2_req", {31'd0, dbus.req}, 32'd1);
    rst = 1'b1;
    @(posedge sys_clk);
    #1;
    rst = 1'b0;
    chk("abort_req", {31'd0, dbus.req}, 32'd0);
    chk("abort_stall", {31'd0, stall}, 32'd0);
    dbus.ack = 1'b1;
    dbus.rdata = 32'h11111111;
    @(posedge sys_clk);
    #1;
    dbus.ack = 1'b0;
    dbus.rdata = 32'd0;
    chk("late_ack_req", {31'd0, dbus.req}, 32'd0);
    repeat (3) @(posedge sys_clk);
    #1;
    chk("scoreboard_empty", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
